// File: rtl/ex1_pkg.sv
// ex1_pkg: shared constants for the even up/down counter
package ex1_pkg;
  localparam logic [3:0] STEP = 4'd2;
  localparam logic [3:0] MAX_EVEN = 4'b1110;
endpackage

// File: rtl/ex1_t_ff.sv
// t_ff: T flip-flop with synchronous active-high reset
module t_ff (
  input  logic clk,
  input  logic reset,
  input  logic T,
  output logic Q
);
  always_ff @(posedge clk) Q <= reset ? 1'b0 : Q ^ T;
endmodule

// File: rtl/ex1.sv
// ex1: 4-bit even up/down counter built from T flip-flops and gate-level toggle logic
module ex1
  import ex1_pkg::*;
(
  output logic Q3,
  output logic Q2,
  output logic Q1,
  output logic Q0,
  input  logic Y,
  input  logic reset,
  input  logic clk
);
  logic ny, nq1, nq2, up2, dn2, up3, dn3, t2, t3;
  not g_ny (ny, Y);
  not g_nq1 (nq1, Q1);
  not g_nq2 (nq2, Q2);
  and g_up2 (up2, Y, Q1);
  and g_dn2 (dn2, ny, nq1);
  or  g_t2 (t2, up2, dn2);
  and g_up3 (up3, Y, Q1, Q2);
  and g_dn3 (dn3, ny, nq1, nq2);
  or  g_t3 (t3, up3, dn3);
  t_ff u_ff0 (.clk(clk), .reset(reset), .T(1'b0), .Q(Q0));
  t_ff u_ff1 (.clk(clk), .reset(reset), .T(1'b1), .Q(Q1));
  t_ff u_ff2 (.clk(clk), .reset(reset), .T(t2), .Q(Q2));
  t_ff u_ff3 (.clk(clk), .reset(reset), .T(t3), .Q(Q3));
endmodule

// File: tb/tb_ex1.sv
// tb_ex1: directed vector table plus randomized model check for ex1
module tb_ex1;
  import ex1_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic Y = 1'b0;
  logic Q3, Q2, Q1, Q0;
  int checks = 0;
  int errors = 0;
  int model;
  typedef struct {
    logic rst;
    logic y;
    logic [3:0] exp;
    string name;
  } vec_t;
  vec_t vecs[$];
  ex1 dut (.Q3(Q3), .Q2(Q2), .Q1(Q1), .Q0(Q0), .Y(Y), .reset(reset), .clk(clk));
  always #5 clk = ~clk;
  function automatic logic [3:0] q();
    return {Q3, Q2, Q1, Q0};
  endfunction
  task automatic step(input logic r, input logic y, input logic [3:0] exp, input string name);
    reset = r;
    Y = y;
    @(posedge clk);
    #1;
    checks++;
    if (q() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, q(), exp);
    end
    checks++;
    if (Q0 !== 1'b0) begin
      errors++;
      $display("FAIL %s lsb: got Q0=%b expected 0", name, Q0);
    end
  endtask
  task automatic add(input logic r, input logic y, input logic [3:0] e, input string n);
    vec_t v;
    v.rst = r;
    v.y = y;
    v.exp = e;
    v.name = n;
    vecs.push_back(v);
  endtask
  initial begin
    add(1, 1, 4'd0, "reset_y1");
    add(1, 0, 4'd0, "reset_hold_y0");
    add(1, 1, 4'd0, "reset_hold_y1");
    add(0, 1, 4'd2, "up1");
    add(0, 1, 4'd4, "up2");
    add(0, 1, 4'd6, "up3");
    add(0, 1, 4'd8, "up4");
    add(0, 1, 4'd10, "up5");
    add(0, 1, 4'd12, "up6");
    add(0, 1, MAX_EVEN, "up7");
    add(0, 1, 4'd0, "up_wrap");
    add(0, 1, 4'd2, "up9");
    add(1, 1, 4'd0, "reset_before_down");
    add(0, 0, MAX_EVEN, "down_wrap");
    add(0, 0, 4'd12, "down2");
    add(0, 0, 4'd10, "down3");
    add(1, 0, 4'd0, "reset_before_rev");
    add(0, 1, 4'd2, "rev_up1");
    add(0, 1, 4'd4, "rev_up2");
    add(0, 1, 4'd6, "rev_up3");
    add(0, 0, 4'd4, "rev_down1");
    add(0, 0, 4'd2, "rev_down2");
    add(0, 1, 4'd4, "rev_up_again");
    add(0, 1, 4'd6, "mid_up1");
    add(0, 1, 4'd8, "mid_up2");
    add(0, 1, 4'd10, "mid_up3");
    add(1, 1, 4'd0, "mid_reset");
    add(0, 0, MAX_EVEN, "mid_resume_down");
    @(negedge clk);
    foreach (vecs[i]) step(vecs[i].rst, vecs[i].y, vecs[i].exp, vecs[i].name);
    model = MAX_EVEN;
    for (int i = 0; i < 300; i++) begin
      logic r, y;
      r = ($urandom_range(0, 15) == 0);
      y = $urandom_range(0, 1);
      model = r ? 0 : (y ? model + STEP : model - STEP + 16) % 16;
      step(r, y, 4'(model), "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
